store_req_queue: RTL and testbench

STORE_REQ_QUEUE -- requirements
Module: store_req_queue

---
 rtl/store_req_queue.sv | 83 ++++++++
 tb/tb_store_req_queue.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/store_req_queue.sv
// store_req_queue: FIFO between the issue stage and the store unit, with a zero-latency bypass when empty
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        discard every queued request
//   valid_i        issue-stage store/AMO request present
//   lsu_ctrl_i     issued request payload
//   ready_o        queue accepts a request this cycle (count < DEPTH)
//   valid_o        request presented to the store unit
//   lsu_ctrl_o     oldest request (or the input itself while empty)
//   pop_i          store unit consumed the presented request
//   empty_o        no request stored
//   count_o        stored-entry count
package store_req_queue_pkg;
    typedef struct packed {
        logic [63:0] vaddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [3:0]  operation;
        logic [2:0]  trans_id;
        logic [63:0] pc;
    } lsu_ctrl_t;
endpackage

module store_req_queue
    import store_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  lsu_ctrl_t                  lsu_ctrl_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output lsu_ctrl_t                  lsu_ctrl_o,
    input  logic                       pop_i,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    lsu_ctrl_t     mem_q [DEPTH];
    logic          push, pop, store, take;

    assign empty_o    = count_q == '0;
    assign count_o    = count_q;
    assign ready_o    = count_q < CW'(DEPTH);
    assign valid_o    = empty_o ? valid_i : 1'b1;
    assign lsu_ctrl_o = empty_o ? lsu_ctrl_i : mem_q[rd_q];
    assign push       = valid_i & ready_o & ~flush_i;
    assign pop        = pop_i & valid_o & ~flush_i;
    // a request bypassed and consumed in the same cycle while empty is never stored
    assign store      = push & ~(empty_o & pop);
    assign take       = pop & ~empty_o;

    always_comb begin
        count_d = flush_i ? '0 : count_q + CW'(store) - CW'(take);
        wr_d    = flush_i ? '0 : wr_q + PW'(store);
        rd_d    = flush_i ? '0 : rd_q + PW'(take);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // payload storage needs no reset: it is hidden whenever count is 0
    always_ff @(posedge clk_i) begin
        if (store) mem_q[wr_q] <= lsu_ctrl_i;
    end
endmodule

// File: tb/tb_store_req_queue.sv
// tb_store_req_queue: directed self-checking bench for store_req_queue (DEPTH = 2)
module tb_store_req_queue;
    import store_req_queue_pkg::*;

    logic      clk_i = 1'b0;
    logic      rst_i, flush_i, valid_i, pop_i;
    lsu_ctrl_t lsu_ctrl_i, lsu_ctrl_o;
    logic      ready_o, valid_o, empty_o;
    logic [1:0] count_o;
    int checks = 0;
    int failures = 0;

    store_req_queue #(.DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .lsu_ctrl_i(lsu_ctrl_i), .ready_o(ready_o), .valid_o(valid_o),
        .lsu_ctrl_o(lsu_ctrl_o), .pop_i(pop_i), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [2:0] id);
        valid_i = v;
        lsu_ctrl_i = '0;
        lsu_ctrl_i.trans_id = id;
        lsu_ctrl_i.data = 64'hD000 + 64'(id);
        lsu_ctrl_i.vaddr = 64'h1000 + 64'(id) * 8;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; pop_i = 1'b0;
        req(1'b1, 3'd7);
        #2;
        chk("rst_count", 64'(count_o), 0);
        chk("rst_ready", 64'(ready_o), 1);
        chk("rst_empty", 64'(empty_o), 1);
        chk("rst_bypass_valid", 64'(valid_o), 1);
        chk("rst_bypass_id", 64'(lsu_ctrl_o.trans_id), 7);
        req(1'b0, 3'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        step();

        // bypass with same-cycle pop
        req(1'b1, 3'd3); pop_i = 1'b1; #1;
        chk("byp_valid", 64'(valid_o), 1);
        chk("byp_id", 64'(lsu_ctrl_o.trans_id), 3);
        chk("byp_data", lsu_ctrl_o.data, 64'hD003);
        step();
        req(1'b0, 3'd0); pop_i = 1'b0; #1;
        chk("byp_count", 64'(count_o), 0);
        chk("byp_valid_idle", 64'(valid_o), 0);

        // pop while nothing presented
        pop_i = 1'b1; step(); pop_i = 1'b0; #1;
        chk("underflow_count", 64'(count_o), 0);

        // fill
        req(1'b1, 3'd1); #1;
        chk("fill_ready0", 64'(ready_o), 1);
        step();
        chk("fill_count1", 64'(count_o), 1);
        chk("fill_id_c1", 64'(lsu_ctrl_o.trans_id), 1);
        req(1'b1, 3'd2); step();
        chk("fill_count2", 64'(count_o), 2);
        chk("fill_ready_full", 64'(ready_o), 0);
        chk("fill_id_c2", 64'(lsu_ctrl_o.trans_id), 1);
        req(1'b1, 3'd3); step();
        chk("full_hold_count", 64'(count_o), 2);
        chk("full_hold_id", 64'(lsu_ctrl_o.trans_id), 1);
        chk("full_empty", 64'(empty_o), 0);

        // drain one, then simultaneous push/pop at count 1
        req(1'b0, 3'd0); pop_i = 1'b1; step();
        chk("drain_count", 64'(count_o), 1);
        chk("drain_id", 64'(lsu_ctrl_o.trans_id), 2);
        req(1'b1, 3'd5); step();
        chk("pp_count", 64'(count_o), 1);
        chk("pp_id", 64'(lsu_ctrl_o.trans_id), 5);
        chk("pp_data", lsu_ctrl_o.data, 64'hD005);

        // wrap: six push/pop pairs keep count at 1
        for (int i = 0; i < 6; i++) begin
            req(1'b1, 3'(i)); #1;
            chk($sformatf("wrap_out%0d", i), 64'(lsu_ctrl_o.trans_id), (i == 0) ? 64'd5 : 64'(i - 1));
            step();
            chk($sformatf("wrap_count%0d", i), 64'(count_o), 1);
        end
        chk("wrap_last", 64'(lsu_ctrl_o.trans_id), 5);
        chk("wrap_last_vaddr", lsu_ctrl_o.vaddr, 64'h1028);
        req(1'b0, 3'd0); step();
        pop_i = 1'b0; #1;
        chk("wrap_empty", 64'(empty_o), 1);

        // flush at count 2 with a concurrent push
        req(1'b1, 3'd1); step();
        req(1'b1, 3'd2); step();
        chk("pre_flush_count", 64'(count_o), 2);
        flush_i = 1'b1; req(1'b1, 3'd6); step();
        flush_i = 1'b0; req(1'b0, 3'd0); #1;
        chk("flush_count", 64'(count_o), 0);
        chk("flush_empty", 64'(empty_o), 1);
        chk("flush_valid", 64'(valid_o), 0);

        // bypass stays live during flush
        flush_i = 1'b1; req(1'b1, 3'd4); #1;
        chk("flush_byp_valid", 64'(valid_o), 1);
        chk("flush_byp_id", 64'(lsu_ctrl_o.trans_id), 4);
        step();
        flush_i = 1'b0; req(1'b0, 3'd0); #1;
        chk("flush_byp_count", 64'(count_o), 0);

        // asynchronous reset at count 2
        req(1'b1, 3'd1); step();
        req(1'b1, 3'd2); step();
        req(1'b0, 3'd0);
        chk("pre_rst_count", 64'(count_o), 2);
        #2 rst_i = 1'b1; #1;
        chk("arst_count", 64'(count_o), 0);
        chk("arst_ready", 64'(ready_o), 1);
        chk("arst_empty", 64'(empty_o), 1);
        @(negedge clk_i); rst_i = 1'b0;

        // queue works again after reset
        req(1'b1, 3'd2); step();
        req(1'b0, 3'd0); #1;
        chk("post_rst_count", 64'(count_o), 1);
        chk("post_rst_id", 64'(lsu_ctrl_o.trans_id), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
